// File: rtl/decoder_3x8_frame.sv
// ---------------------------------------------------------------------------
// decoder_3x8_frame
//
// Receive side of an 8-to-3 priority-encoder link. An upstream scanner sends
// one 3-bit code {x,y,z} per handshake, highest set bit first, and closes the
// frame with a V=0 terminator. This block decodes each code to one-hot and
// ORs it into an 8-bit vector that rebuilds the scanner's original input.
// A frame also closes on its own after MAX_CODES valid codes. The finished
// frame is held under a valid/ready handshake until the consumer takes it.
//
// Parameters
//   STRICT_ORDER : 1 = flag err when codes in a frame are not strictly
//                  descending (a repeated code also counts); 0 = no check
//   MAX_CODES    : valid codes per frame before an automatic close (1..8)
//
// Ports
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   in_valid, in_ready : code handshake; in_ready is high only while collecting
//   x, y, z            : code bits, x is the MSB (k = 4x + 2y + z)
//   V                  : 1 = valid code, 0 = frame terminator
//   D                  : accumulated vector, D[k] set for each code k
//   onehot             : one-hot decode of the last accepted valid code
//   cnt                : number of V=1 codes accepted in the current frame
//   err                : order violation seen in the current frame (sticky)
//   out_valid          : frame result available on D/cnt/err
//   out_ready          : consumer takes the result
// ---------------------------------------------------------------------------
module decoder_3x8_frame #(
    parameter int STRICT_ORDER = 1,
    parameter int MAX_CODES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic       V,
    output logic [7:0] D,
    output logic [7:0] onehot,
    output logic [3:0] cnt,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_CODES);

    state_t     r_state;
    logic [7:0] r_D;
    logic [7:0] r_onehot;
    logic [3:0] r_cnt;
    logic       r_err;
    logic       r_out_valid;
    logic [2:0] r_last_code;

    state_t     w_state_nxt;
    logic [7:0] w_D_nxt;
    logic [7:0] w_onehot_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_err_nxt;
    logic       w_out_valid_nxt;
    logic [2:0] w_last_code_nxt;

    logic       w_accept;
    logic [2:0] w_code;
    logic [3:0] w_cnt_inc;
    logic [7:0] w_code_onehot;

    // in_ready comes straight from the state register so the upstream
    // scanner never sees a combinational path back to its own in_valid.
    assign in_ready      = (r_state == S_COLLECT);
    assign w_accept      = in_valid & in_ready;
    assign w_code        = {x, y, z};
    assign w_cnt_inc     = r_cnt + 4'd1;
    assign w_code_onehot = 8'b0000_0001 << w_code;

    always_comb begin
        w_state_nxt     = r_state;
        w_D_nxt         = r_D;
        w_onehot_nxt    = r_onehot;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_out_valid_nxt = r_out_valid;
        w_last_code_nxt = r_last_code;

        case (r_state)
            S_COLLECT: begin
                if (w_accept) begin
                    if (V) begin
                        w_D_nxt         = r_D | w_code_onehot;
                        w_onehot_nxt    = w_code_onehot;
                        w_cnt_nxt       = w_cnt_inc;
                        w_last_code_nxt = w_code;
                        // The first code of a frame has no predecessor, so
                        // the comparison only applies once cnt is non-zero.
                        if ((STRICT_ORDER != 0) && (r_cnt != 4'd0) &&
                            (w_code >= r_last_code)) begin
                            w_err_nxt = 1'b1;
                        end
                        if (w_cnt_inc == MAX_CNT) begin
                            w_state_nxt     = S_HOLD;
                            w_out_valid_nxt = 1'b1;
                        end
                    end else begin
                        // Terminator: code bits carry no meaning here.
                        w_onehot_nxt    = 8'h00;
                        w_state_nxt     = S_HOLD;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt     = S_COLLECT;
                    w_D_nxt         = 8'h00;
                    w_onehot_nxt    = 8'h00;
                    w_cnt_nxt       = 4'd0;
                    w_err_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b0;
                    w_last_code_nxt = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_D         <= 8'h00;
            r_onehot    <= 8'h00;
            r_cnt       <= 4'd0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_last_code <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_D         <= w_D_nxt;
            r_onehot    <= w_onehot_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_last_code <= w_last_code_nxt;
        end
    end

    assign D         = r_D;
    assign onehot    = r_onehot;
    assign cnt       = r_cnt;
    assign err       = r_err;
    assign out_valid = r_out_valid;

endmodule

// File: doc/decoder_3x8_frame.md
Name: decoder_3x8_frame

Overview:
Receive-side counterpart of the 8-to-3 priority encoder (D[7:0] -> x,y,z,V). An upstream scanner repeatedly priority-encodes a vector and clears the reported bit, sending one code per handshake. This block decodes each 3-bit code back to one-hot and accumulates the codes into the original 8-bit vector. A frame ends on a V=0 terminator or after MAX_CODES codes; the result is then held under a valid/ready handshake.

Parameters:
STRICT_ORDER, 1, 1 = flag an error when codes within a frame are not strictly descending; 0 = no order check.
MAX_CODES, 8, codes per frame before an automatic frame end; legal range 1..8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  code present
in_ready  output  1  block can accept a code
x  input  1  code bit 2 (MSB)
y  input  1  code bit 1
z  input  1  code bit 0 (LSB)
V  input  1  1 = valid code; 0 = frame terminator
D  output  8  accumulated vector; D[k] set for each code k received
onehot  output  8  one-hot decode of the last accepted valid code
cnt  output  4  number of V=1 codes accepted in the current frame (0..8)
err  output  1  order violation seen in the current frame
out_valid  output  1  frame result available
out_ready  input  1  consumer takes the result

Behaviour:
- States: COLLECT and HOLD. All outputs are registered.
- in_ready = (state == COLLECT). It is decoded from the state register only and never depends on in_valid.
- accept = in_valid & in_ready.
- Reset (rst=1 at a clock edge, from any state, including mid-frame or in HOLD): next state COLLECT; D=0, onehot=0, cnt=0, err=0, out_valid=0, and the internal last_code is cleared. Any partial or held frame is discarded.
- COLLECT, accept with V=1, where k = {x,y,z}:
  - D[k] <= 1; onehot <= 1<<k; cnt <= cnt+1; last_code <= k.
  - If STRICT_ORDER=1 and cnt != 0 and k >= last_code, then err <= 1. A duplicate code therefore sets err. err is sticky until the frame is released.
  - If cnt+1 == MAX_CODES: move to HOLD and set out_valid <= 1 in the same edge.
- COLLECT, accept with V=0: x, y, z are ignored; onehot <= 0; D, cnt and err are unchanged; move to HOLD and set out_valid <= 1. An empty frame (terminator first) is legal and yields D=0, cnt=0.
- COLLECT, no accept: all registers hold.
- Latency: out_valid is asserted in the cycle after the frame-ending accept.
- HOLD: out_valid=1; D, cnt, err and onehot are stable; in_ready=0, so in_valid is ignored.
- HOLD with out_ready=1 at an edge: next state COLLECT; D=0, onehot=0, cnt=0, err=0, out_valid=0. in_ready returns to 1 in that next cycle.
- out_ready is ignored while out_valid=0.
- Duplicate code with STRICT_ORDER=0: the D bit stays set, cnt still increments, err stays 0.
- Width rules:
  - cnt is 4 bits and never exceeds MAX_CODES, so it cannot wrap.
  - Code-to-bit mapping: k = 4x + 2y + z. This is the inverse of the encoder: D[7] -> code 7.
- D is visible while it is partially accumulated during COLLECT, but it is defined as the frame result only while out_valid=1.
- If rst and out_ready are both high at the same edge, rst wins (same end state as reset).

Test Plan:
1. After reset, send codes 7, 5, 2, then V=0 (one per cycle, out_ready=1) -> one cycle after the terminator: out_valid=1, D=8'b1010_0100, cnt=3, err=0, onehot=0; the cycle after that: out_valid=0, D=0.
2. Empty frame: terminator only (V=0, any x,y,z) -> out_valid=1, D=8'h00, cnt=0, err=0.
3. Order error: send codes 3, then 6, then V=0 -> D=8'h48, cnt=2, err=1. Repeat code 4 twice with STRICT_ORDER=0 -> D=8'h10, cnt=2, err=0.
4. Auto end: send codes 7 down to 0 with no terminator (MAX_CODES=8) -> after the 8th accept, out_valid=1, D=8'hFF, cnt=8, err=0, in_ready=0. With MAX_CODES=2, codes 6, 1 -> D=8'h42, cnt=2.
5. Backpressure: result held with out_ready=0 for 5 cycles while in_valid=1 and codes toggle -> in_ready=0 and D/cnt/err unchanged throughout; raise out_ready -> next cycle out_valid=0, D=0, in_ready=1.
6. Mid-frame reset: accept codes 4 and 1, then assert rst for one cycle -> next cycle D=0, onehot=0, cnt=0, err=0, out_valid=0, in_ready=1. A subsequent frame with code 0 then V=0 -> D=8'h01, cnt=1.
